// File: rtl/fifo_pkg.sv
// fifo_pkg: shared helpers and flag grouping for fifo_sc_m.
package fifo_pkg;

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
    } fifo_flags_t;

    function automatic int calc_ptr_w(input int depth);
        return $clog2(depth);
    endfunction

    function automatic int calc_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Modulo-depth increment, valid for any depth rather than only powers of two
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr == depth - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_ptr_m.sv
// fifo_ptr_m: modulo-DEPTH pointer register with enable and synchronous clear.
module fifo_ptr_m
    import fifo_pkg::*;
#(
    parameter int DEPTH = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_clear,
    input  logic                          i_en,
    output logic [calc_ptr_w(DEPTH)-1:0]  o_ptr
);
    localparam int PTR_W = calc_ptr_w(DEPTH);

    logic [PTR_W-1:0] r_ptr;

    always_ff @(posedge clk) begin
        if (rst || i_clear)
            r_ptr <= '0;
        else if (i_en)
            r_ptr <= PTR_W'(ptr_inc(32'(r_ptr), DEPTH));
    end

    assign o_ptr = r_ptr;
endmodule

// File: rtl/fifo_sc_m.sv
// fifo_sc_m: single-clock first-word-fall-through FIFO with count, programmable
// almost flags, overflow/underflow pulses and synchronous flush.
module fifo_sc_m
    import fifo_pkg::*;
#(
    parameter type DATA_ITEM_TYPE = logic,
    parameter int  DEPTH          = 32,
    parameter int  AFULL_THRESH   = DEPTH - 2,
    parameter int  AEMPTY_THRESH  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  DATA_ITEM_TYPE                 tail,
    input  logic                          push,
    output DATA_ITEM_TYPE                 head,
    input  logic                          pop,
    output logic                          full,
    output logic                          empty,
    output logic                          almost_full,
    output logic                          almost_empty,
    output logic [calc_cnt_w(DEPTH)-1:0]  count,
    output logic                          overflow,
    output logic                          underflow
);
    localparam int PTR_W = calc_ptr_w(DEPTH);
    localparam int CNT_W = calc_cnt_w(DEPTH);
    localparam logic [CNT_W-1:0] C_DEPTH = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] C_AF    = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] C_AE    = CNT_W'(AEMPTY_THRESH);

    DATA_ITEM_TYPE    r_mem [DEPTH];
    logic [CNT_W-1:0] r_count;
    fifo_flags_t      r_flags;
    logic             r_ovf;
    logic             r_udf;

    logic [PTR_W-1:0] w_wr_ptr;
    logic [PTR_W-1:0] w_rd_ptr;
    logic             w_wr_acc;
    logic             w_rd_acc;
    logic [CNT_W-1:0] w_cnt_nxt;
    fifo_flags_t      w_flags_nxt;

    // A full FIFO still accepts a push when a pop frees a slot in the same cycle
    assign w_wr_acc  = push && (!r_flags.full || pop);
    assign w_rd_acc  = pop && !r_flags.empty;
    assign w_cnt_nxt = r_count + CNT_W'(w_wr_acc) - CNT_W'(w_rd_acc);

    always_comb begin
        w_flags_nxt.full         = w_cnt_nxt == C_DEPTH;
        w_flags_nxt.empty        = w_cnt_nxt == '0;
        w_flags_nxt.almost_full  = w_cnt_nxt >= C_AF;
        w_flags_nxt.almost_empty = w_cnt_nxt <= C_AE;
    end

    fifo_ptr_m #(.DEPTH(DEPTH)) u_wr_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear),
        .i_en    (w_wr_acc),
        .o_ptr   (w_wr_ptr)
    );

    fifo_ptr_m #(.DEPTH(DEPTH)) u_rd_ptr (
        .clk     (clk),
        .rst     (rst),
        .i_clear (clear),
        .i_en    (w_rd_acc),
        .o_ptr   (w_rd_ptr)
    );

    // Storage is deliberately left uninitialised by reset and flush
    always_ff @(posedge clk) begin
        if (!rst && !clear && w_wr_acc)
            r_mem[w_wr_ptr] <= tail;
    end

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_count <= '0;
            r_flags <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0, almost_empty: 1'b1};
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            r_count <= w_cnt_nxt;
            r_flags <= w_flags_nxt;
            r_ovf   <= push && !w_wr_acc;
            r_udf   <= pop && !w_rd_acc;
        end
    end

    assign head         = r_mem[w_rd_ptr];
    assign count        = r_count;
    assign full         = r_flags.full;
    assign empty        = r_flags.empty;
    assign almost_full  = r_flags.almost_full;
    assign almost_empty = r_flags.almost_empty;
    assign overflow     = r_ovf;
    assign underflow    = r_udf;
endmodule

// File: tb/tb_fifo_sc_m.sv
// tb_fifo_sc_m: directed scenarios for fifo_sc_m at DEPTH 5, thresholds 3/1.
module tb_fifo_sc_m;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       clear = 1'b0;
    logic [7:0] tail = 8'h00;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] head;
    logic       full, empty, almost_full, almost_empty, overflow, underflow;
    logic [2:0] count;

    int n_pass = 0;
    int n_total = 0;
    logic [7:0] q [$];

    fifo_sc_m #(
        .DATA_ITEM_TYPE (logic [7:0]),
        .DEPTH          (5),
        .AFULL_THRESH   (3),
        .AEMPTY_THRESH  (1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .clear        (clear),
        .tail         (tail),
        .push         (push),
        .head         (head),
        .pop          (pop),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic p, input logic r, input logic [7:0] d);
        push = p;
        pop  = r;
        tail = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, 1'b1, 8'h55);
        tick();
        tick();
        n_total++;
        if ({count, empty, almost_empty, full, almost_full, overflow, underflow} !== {3'd0, 6'b110000})
            $display("FAIL reset: {count,e,ae,f,af,ovf,udf} got %b want %b",
                     {count, empty, almost_empty, full, almost_full, overflow, underflow}, {3'd0, 6'b110000});
        else n_pass++;
        rst = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        tick();
    endtask

    task automatic test_single();
        drive(1'b1, 1'b0, 8'hA5);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if ({empty, head, count} !== {1'b0, 8'hA5, 3'd1})
            $display("FAIL single_push: {empty,head,count} got %h want %h", {empty, head, count}, {1'b0, 8'hA5, 3'd1});
        else n_pass++;
        drive(1'b0, 1'b1, 8'h00);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if ({empty, count} !== {1'b1, 3'd0})
            $display("FAIL single_pop: {empty,count} got %b want %b", {empty, count}, {1'b1, 3'd0});
        else n_pass++;
    endtask

    task automatic test_full_overflow();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 8'h10 + 8'(i));
            q.push_back(8'h10 + 8'(i));
            tick();
        end
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if ({full, count} !== {1'b1, 3'd5})
            $display("FAIL fill5: {full,count} got %b want %b", {full, count}, {1'b1, 3'd5});
        else n_pass++;
        drive(1'b1, 1'b0, 8'hFF);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if ({overflow, full, count, head} !== {1'b1, 1'b1, 3'd5, 8'h10})
            $display("FAIL overflow: {ovf,full,count,head} got %h want %h", {overflow, full, count, head}, {1'b1, 1'b1, 3'd5, 8'h10});
        else n_pass++;
        tick();
        n_total++;
        if (overflow !== 1'b0)
            $display("FAIL overflow_pulse_len: got %b want 0", overflow);
        else n_pass++;
    endtask

    task automatic test_full_stream();
        int errs = 0;
        for (int i = 0; i < 20; i++) begin
            if (head !== q[0] || full !== 1'b1) errs++;
            drive(1'b1, 1'b1, 8'h20 + 8'(i));
            tick();
            void'(q.pop_front());
            q.push_back(8'h20 + 8'(i));
        end
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if (errs !== 0)
            $display("FAIL stream_full: head/full errors got %0d want 0", errs);
        else n_pass++;
        n_total++;
        if ({full, count, overflow, underflow} !== {1'b1, 3'd5, 2'b00})
            $display("FAIL stream_state: {full,count,ovf,udf} got %b want %b", {full, count, overflow, underflow}, {1'b1, 3'd5, 2'b00});
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            n_total++;
            if (head !== 8'h2F + 8'(i))
                $display("FAIL drain_order[%0d]: head got %h want %h", i, head, 8'h2F + 8'(i));
            else n_pass++;
            drive(1'b0, 1'b1, 8'h00);
            tick();
        end
        drive(1'b0, 1'b0, 8'h00);
        q.delete();
        n_total++;
        if ({empty, count} !== {1'b1, 3'd0})
            $display("FAIL drain_empty: {empty,count} got %b want %b", {empty, count}, {1'b1, 3'd0});
        else n_pass++;
    endtask

    task automatic test_underflow();
        drive(1'b0, 1'b1, 8'h00);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if ({underflow, empty, count} !== {2'b11, 3'd0})
            $display("FAIL underflow: {udf,empty,count} got %b want %b", {underflow, empty, count}, {2'b11, 3'd0});
        else n_pass++;
        tick();
        n_total++;
        if (underflow !== 1'b0)
            $display("FAIL underflow_pulse_len: got %b want 0", underflow);
        else n_pass++;
        drive(1'b1, 1'b1, 8'h3C);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if ({underflow, empty, count, head} !== {2'b10, 3'd1, 8'h3C})
            $display("FAIL push_pop_empty: {udf,empty,count,head} got %h want %h", {underflow, empty, count, head}, {2'b10, 3'd1, 8'h3C});
        else n_pass++;
        drive(1'b0, 1'b1, 8'h00);
        tick();
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_thresholds();
        logic [1:0] fill_exp [4] = '{2'b01, 2'b00, 2'b10, 2'b10};
        logic [1:0] drain_exp [4] = '{2'b10, 2'b00, 2'b01, 2'b01};
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 8'h40 + 8'(i));
            tick();
            n_total++;
            if ({almost_full, almost_empty, count} !== {fill_exp[i], 3'(i + 1)})
                $display("FAIL fill_flags[%0d]: {af,ae,count} got %b want %b", i, {almost_full, almost_empty, count}, {fill_exp[i], 3'(i + 1)});
            else n_pass++;
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 8'h00);
            tick();
            n_total++;
            if ({almost_full, almost_empty, count} !== {drain_exp[i], 3'(3 - i)})
                $display("FAIL drain_flags[%0d]: {af,ae,count} got %b want %b", i, {almost_full, almost_empty, count}, {drain_exp[i], 3'(3 - i)});
            else n_pass++;
        end
        drive(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_clear();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b0, 8'h50 + 8'(i));
            tick();
        end
        clear = 1'b1;
        drive(1'b1, 1'b0, 8'h99);
        tick();
        clear = 1'b0;
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if ({count, empty, almost_empty, full, almost_full, overflow, underflow} !== {3'd0, 6'b110000})
            $display("FAIL clear: {count,e,ae,f,af,ovf,udf} got %b want %b",
                     {count, empty, almost_empty, full, almost_full, overflow, underflow}, {3'd0, 6'b110000});
        else n_pass++;
        drive(1'b1, 1'b0, 8'h77);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if ({empty, head, count} !== {1'b0, 8'h77, 3'd1})
            $display("FAIL after_clear_push: {empty,head,count} got %h want %h", {empty, head, count}, {1'b0, 8'h77, 3'd1});
        else n_pass++;
        drive(1'b0, 1'b1, 8'h00);
        tick();
        drive(1'b0, 1'b0, 8'h00);
        n_total++;
        if ({empty, count, underflow} !== {1'b1, 3'd0, 1'b0})
            $display("FAIL after_clear_pop: {empty,count,udf} got %b want %b", {empty, count, underflow}, {1'b1, 3'd0, 1'b0});
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_overflow();
        test_full_stream();
        test_underflow();
        test_thresholds();
        test_clear();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/fifo_sc_m.md
# fifo_sc_m

Parametrised single-clock first-word-fall-through FIFO built in plain RTL, with no vendor primitive. It is the single-clock successor to the team's instantiated dual-clock FIFO wrapper. Compared with that wrapper it adds:
- any depth ≥ 2, not only powers of two;
- occupancy count;
- programmable almost-full and almost-empty flags;
- overflow and underflow pulses;
- synchronous flush.

It is used between pipeline stages and stream adapters inside one clock domain.

## Interface
Parameters:
- DATA_ITEM_TYPE, logic: payload type; width is $bits(DATA_ITEM_TYPE).
- DEPTH, 32: number of entries, ≥ 2; any integer.
- AFULL_THRESH, DEPTH-2: almost_full asserts when count ≥ AFULL_THRESH.
- AEMPTY_THRESH, 2: almost_empty asserts when count ≤ AEMPTY_THRESH.

Ports:
- clk, in, 1: the single clock. All logic is rising-edge.
- rst, in, 1: reset. Synchronous, active-high.
- clear, in, 1: synchronous flush. Same effect as rst on state; takes priority over push and pop.
- tail, in, DATA_ITEM_TYPE: write data.
- push, in, 1: write request.
- head, out, DATA_ITEM_TYPE: oldest entry. Valid whenever empty = 0.
- pop, in, 1: read acknowledge. Removes the entry shown on head.
- full, out, 1: count == DEPTH.
- empty, out, 1: count == 0.
- almost_full, out, 1: count ≥ AFULL_THRESH.
- almost_empty, out, 1: count ≤ AEMPTY_THRESH.
- count, out, $clog2(DEPTH+1): current occupancy.
- overflow, out, 1: one-cycle pulse; a push was rejected.
- underflow, out, 1: one-cycle pulse; a pop was rejected.

## Operation
- Storage is an array of DEPTH × DATA_ITEM_TYPE, with write pointer wr_ptr and read pointer rd_ptr.
  - Each pointer is $clog2(DEPTH) bits.
  - Each pointer increments modulo DEPTH: value DEPTH-1 wraps to 0. No power-of-two masking.
- Accepted push (wr_acc): push && (!full || pop).
  - Push while full is accepted only if pop occurs in the same cycle.
- Accepted pop (rd_acc): pop && !empty.
  - Pop while empty is always rejected, even with a simultaneous push. The pushed word is still written.
- On wr_acc: mem[wr_ptr] <= tail; wr_ptr advances.
- On rd_acc: rd_ptr advances.
- count next value:
  - count + 1 if wr_acc only;
  - count − 1 if rd_acc only;
  - unchanged if both or neither.
- Flags are registered and derived from the next count value, so they are glitch-free and coherent with count.
- overflow <= push && !wr_acc. underflow <= pop && !rd_acc. Each lasts one cycle.
- head = mem[rd_ptr], read combinationally. The content of head is unspecified while empty = 1.
- rst or clear:
  - pointers and count go to 0;
  - empty = 1, almost_empty = 1;
  - full, almost_full, overflow and underflow go to 0;
  - array contents are not cleared.
  - Any push or pop in the same cycle is ignored and produces no overflow or underflow pulse.
  - Asserting either mid-stream discards all stored data.

## Timing
- Reset values: count 0, empty 1, almost_empty 1, all other flags 0.
- Write-to-read latency is 1 cycle. Push accepted at edge N makes empty = 0 and head = tail(N) visible after edge N.
- Pop at edge N makes head present the next entry after edge N, or empty = 1 if none remains.
- Full throughput: one push and one pop per cycle, sustained, at any occupancy including full.
- Flags, count and the overflow/underflow pulses all update on the same edge as the accepted or rejected operation.
- No combinational path from push or pop to any output.

## Structure
- fifo_pkg (shared package):
  - function ptr_inc(ptr, depth) for wrap-around increment;
  - localparam helpers CNT_W and PTR_W;
  - fifo_flags_t struct grouping {full, empty, almost_full, almost_empty}.
- Sub-module fifo_ptr_m: modulo-DEPTH pointer register with enable and sync clear. Instantiated twice, once for write and once for read.
- Top-level contents: array, accept logic, counter, flag registers.

## Test plan
- Reset, then 1 push of 0xA5 → empty drops 1 cycle later, head = 0xA5, count = 1; pop → empty = 1, count = 0.
- DEPTH = 5, 5 pushes → full = 1, count = 5; 6th push alone → overflow pulse 1 cycle, count stays 5, data intact.
- Full, push and pop together for 20 cycles with incrementing data → full stays 1, output sequence strictly in order, pointers wrap 4→0 cleanly.
- Empty, pop alone → underflow pulse; empty with push and pop together → underflow = 1, count = 1.
- AFULL_THRESH = 3, AEMPTY_THRESH = 1: fill 0→4 then drain → almost_full rises at count 3, almost_empty falls at count 2 and rises again at count 1.
- Mid-stream clear with push asserted at count 3 → next cycle count = 0, empty = 1, no overflow; subsequent push/pop behave as after reset.
